ctrl_fsm: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It sits directly upstream of the register file and drives its `d_op`, `rx_op`, `ry_op`, `pc_in` and `in` inputs. It fetches 16-bit instruction words from a synchronous program ROM addressed by the register file's PC and decodes them into register-file and ALU controls. It also selects the write-back data and resolves jumps and branches.

---
 rtl/ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute controller for the 8-bit CPU: one instruction per FETCH, DECODE, EXEC
// sequence, driving register-file selects, write-back data and next-PC.
module ctrl_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  pc_cur,
    input  logic [7:0]  rx_val,
    input  logic [7:0]  alu_y,
    input  logic [15:0] rom_data,
    output logic [7:0]  rom_addr,
    output logic [2:0]  d_op,
    output logic [2:0]  rx_op,
    output logic [2:0]  ry_op,
    output logic [7:0]  pc_in,
    output logic [7:0]  wb_data,
    output logic [2:0]  alu_op,
    output logic        instr_done,
    output logic        halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0] op_s;
    logic [2:0] d_s, x_s, y_s;
    logic [7:0] imm_s;
    logic       illegal_s;
    logic       stop_s;

    assign op_s      = ir_q[15:12];
    assign d_s       = ir_q[11:9];
    assign x_s       = ir_q[8:6];
    assign y_s       = ir_q[5:3];
    assign imm_s     = ir_q[7:0];
    assign illegal_s = (op_s >= 4'd10) && (op_s <= 4'd14);
    assign stop_s    = (op_s == 4'd15) || (illegal_s && HALT_ON_ILLEGAL);

    assign rom_addr   = pc_cur;
    assign instr_done = (state_q == S_EXEC);
    assign halted     = (state_q == S_HALT);

    // Next-state and instruction-register capture.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXEC;
                ir_d    = rom_data;
            end
            S_EXEC: begin
                if (stop_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and IR registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Register-file controls; reset forces a PC load of zero on every edge.
    always_comb begin
        d_op    = 3'd6;
        rx_op   = 3'd0;
        ry_op   = 3'd0;
        alu_op  = 3'd0;
        pc_in   = pc_cur;
        wb_data = 8'h00;
        if (rst) begin
            d_op  = 3'd7;
            pc_in = 8'h00;
        end else if ((state_q == S_EXEC) && !stop_s) begin
            pc_in = pc_cur + 8'd1;
            case (op_s)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                    rx_op   = x_s;
                    ry_op   = y_s;
                    alu_op  = op_s[2:0] - 3'd1;
                    d_op    = d_s;
                    wb_data = alu_y;
                end
                4'd6: begin
                    rx_op   = x_s;
                    ry_op   = y_s;
                    alu_op  = 3'd5;
                    d_op    = d_s;
                    wb_data = alu_y;
                end
                4'd7: begin
                    rx_op   = x_s;
                    ry_op   = y_s;
                    d_op    = d_s;
                    wb_data = imm_s;
                end
                4'd8: begin
                    rx_op   = x_s;
                    ry_op   = y_s;
                    d_op    = 3'd7;
                    wb_data = imm_s;
                end
                4'd9: begin
                    // Branch tests the register named in the d field.
                    rx_op = d_s;
                    ry_op = y_s;
                    if (rx_val == 8'h00) begin
                        d_op    = 3'd7;
                        wb_data = imm_s;
                    end else begin
                        d_op    = 3'd6;
                    end
                end
                default: begin
                    d_op = 3'd6;
                end
            endcase
        end else begin
            d_op = 3'd6;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench: ctrl_fsm with a bench-side register file, ALU and ROM, checked every cycle
// against an instruction-level model of the CPU.
module tb_ctrl_fsm;

    localparam logic [7:0] GPI = 8'h5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  pc_cur;
    logic [7:0]  rx_val;
    logic [7:0]  ry_v;
    logic [7:0]  alu_y;
    logic [15:0] rom_data;
    logic [7:0]  rom_addr;
    logic [2:0]  d_op, rx_op, ry_op, alu_op;
    logic [7:0]  pc_in, wb_data;
    logic        instr_done, halted;

    logic        run_h;
    logic [7:0]  rom_addr_h, pc_in_h, wb_data_h;
    logic [2:0]  d_op_h, rx_op_h, ry_op_h, alu_op_h;
    logic        instr_done_h, halted_h;

    logic [15:0] rom [256];
    logic [7:0]  rf [5] = '{default: 8'h00};
    logic [7:0]  tb_pc = 8'h00;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [2:0] alu3 = 3'd0;

    always #5 clk = ~clk;

    ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .run(run), .pc_cur(pc_cur), .rx_val(rx_val),
        .alu_y(alu_y), .rom_data(rom_data), .rom_addr(rom_addr), .d_op(d_op),
        .rx_op(rx_op), .ry_op(ry_op), .pc_in(pc_in), .wb_data(wb_data),
        .alu_op(alu_op), .instr_done(instr_done), .halted(halted)
    );

    ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1)) u_dut_h (
        .clk(clk), .rst(rst), .run(run_h), .pc_cur(8'h10), .rx_val(8'h00),
        .alu_y(8'h00), .rom_data(16'hA000), .rom_addr(rom_addr_h), .d_op(d_op_h),
        .rx_op(rx_op_h), .ry_op(ry_op_h), .pc_in(pc_in_h), .wb_data(wb_data_h),
        .alu_op(alu_op_h), .instr_done(instr_done_h), .halted(halted_h)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Environment: synchronous ROM, register file with same-cycle reads, external ALU.
    assign pc_cur = tb_pc;
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (d_op == 3'd7) tb_pc <= wb_data;
        else              tb_pc <= pc_in;
        if (d_op < 3'd5) rf[d_op] <= wb_data;
    end

    always_comb begin
        case (rx_op)
            3'd0: rx_val = rf[0];
            3'd1: rx_val = rf[1];
            3'd2: rx_val = rf[2];
            3'd3: rx_val = rf[3];
            3'd4: rx_val = rf[4];
            3'd5: rx_val = GPI;
            3'd6: rx_val = 8'h00;
            default: rx_val = tb_pc;
        endcase
        case (ry_op)
            3'd0: ry_v = rf[0];
            3'd1: ry_v = rf[1];
            3'd2: ry_v = rf[2];
            3'd3: ry_v = rf[3];
            3'd4: ry_v = rf[4];
            3'd5: ry_v = GPI;
            3'd6: ry_v = 8'h00;
            default: ry_v = tb_pc;
        endcase
        alu_y = alu_f(alu_op, rx_val, ry_v);
    end

    // Instruction-level model: architectural state plus a cycle count within the instruction.
    logic [7:0] m_r [5] = '{default: 8'h00};
    logic [7:0] m_pc = 8'h00;
    int         m_phase = 0;
    bit         m_halted = 1'b0;

    function automatic logic [7:0] m_rd(input logic [2:0] sel);
        if (sel < 3'd5) return m_r[sel];
        if (sel == 3'd5) return GPI;
        if (sel == 3'd6) return 8'h00;
        return m_pc;
    endfunction

    always @(negedge clk) begin
        logic [15:0] ins;
        logic [3:0]  op;
        logic [2:0]  d, x, y, e_d, e_rx, e_ry, e_alu;
        logic [7:0]  imm, e_wb, e_pcin;
        bit          e_done, halt_ins;
        if (rst) begin
            chk("rst_d_op", {13'd0, d_op}, 16'd7);
            chk("rst_wb", {8'd0, wb_data}, 16'h0000);
            chk("rst_done", {15'd0, instr_done}, 16'd0);
            chk("rst_halted", {15'd0, halted}, 16'd0);
            m_pc     = 8'h00;
            m_phase  = 0;
            m_halted = 1'b0;
        end else begin
            ins = rom[m_pc];
            op = ins[15:12]; d = ins[11:9]; x = ins[8:6]; y = ins[5:3]; imm = ins[7:0];
            halt_ins = (op == 4'd15);
            e_d = 3'd6; e_rx = 3'd0; e_ry = 3'd0; e_alu = 3'd0; e_wb = 8'h00; e_pcin = m_pc;
            e_done = (m_phase == 3) && !m_halted;
            if (e_done && !halt_ins) begin
                e_pcin = m_pc + 8'd1;
                if (op >= 4'd1 && op <= 4'd9) begin
                    e_rx = x;
                    e_ry = y;
                end
                if (op >= 4'd1 && op <= 4'd6) begin
                    e_alu = (op == 4'd6) ? 3'd5 : 3'(op - 4'd1);
                    e_wb  = alu_f(e_alu, m_rd(x), m_rd(y));
                    e_d   = d;
                end else if (op == 4'd7) begin
                    e_d = d; e_wb = imm;
                end else if (op == 4'd8) begin
                    e_d = 3'd7; e_wb = imm;
                end else if (op == 4'd9) begin
                    e_rx = d;
                    if (m_rd(d) == 8'h00) begin
                        e_d = 3'd7; e_wb = imm;
                    end
                end
            end
            chk("rom_addr", {8'd0, rom_addr}, {8'd0, m_pc});
            chk("pc", {8'd0, tb_pc}, {8'd0, m_pc});
            for (int i = 0; i < 5; i++) chk($sformatf("r%0d", i), {8'd0, rf[i]}, {8'd0, m_r[i]});
            chk("instr_done", {15'd0, instr_done}, {15'd0, e_done});
            chk("halted", {15'd0, halted}, {15'd0, m_halted});
            chk("d_op", {13'd0, d_op}, {13'd0, e_d});
            chk("wb_data", {8'd0, wb_data}, {8'd0, e_wb});
            chk("pc_in", {8'd0, pc_in}, {8'd0, e_pcin});
            chk("rx_op", {13'd0, rx_op}, {13'd0, e_rx});
            chk("ry_op", {13'd0, ry_op}, {13'd0, e_ry});
            chk("alu_op", {13'd0, alu_op}, {13'd0, e_alu});
            if (!m_halted) begin
                case (m_phase)
                    0: m_phase = run ? 1 : 0;
                    1: m_phase = 2;
                    2: m_phase = 3;
                    default: begin
                        if (halt_ins) begin
                            m_halted = 1'b1;
                            m_phase  = 0;
                        end else begin
                            if (e_d == 3'd7) m_pc = e_wb;
                            else begin
                                if (e_d < 3'd5) m_r[e_d] = e_wb;
                                m_pc = e_pcin;
                            end
                            m_phase = run ? 1 : 0;
                        end
                    end
                endcase
            end
        end
    end

    // Counts EXEC cycles and captures the ALU op of the third one.
    always @(negedge clk) begin
        if (!rst && instr_done) begin
            if (done_cnt == 2) alu3 = alu_op;
            done_cnt = done_cnt + 1;
        end
    end

    initial begin
        int budget;
        rst = 1'b1; run = 1'b0; run_h = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h7E2A;
        rom[8'h2A] = 16'h7205; rom[8'h2B] = 16'h7403; rom[8'h2C] = 16'h2050;
        rom[8'h2D] = 16'h9080; rom[8'h2E] = 16'h2000; rom[8'h2F] = 16'h9080;
        rom[8'h80] = 16'hA000; rom[8'h81] = 16'h6740; rom[8'h82] = 16'h58C8;
        rom[8'h83] = 16'h1938; rom[8'h84] = 16'h80FE;
        rom[8'hFE] = 16'h3518; rom[8'hFF] = 16'h0000;
        tick(3);
        chk("h_reset_halted", {15'd0, halted_h}, 16'd0);
        rst = 1'b0;
        tick(1);

        // Single-instruction run: LDI into PC.
        done_cnt = 0;
        run = 1'b1; run_h = 1'b1;
        tick(1);
        run = 1'b0;
        tick(6);
        chk("jump_pc", {8'd0, tb_pc}, 16'h002A);
        chk("jump_rom_addr", {8'd0, rom_addr}, 16'h002A);
        chk("jump_done_pulses", 16'(done_cnt), 16'd1);

        // Program run ending in HALT at address 0.
        rom[8'h00] = 16'hF000;
        done_cnt = 0;
        run = 1'b1;
        budget = 0;
        while (done_cnt < 3 && budget < 40) begin tick(1); budget++; end
        chk("sub_r0", {8'd0, rf[0]}, 16'h0002);
        chk("sub_alu_op", {13'd0, alu3}, 16'd1);
        budget = 0;
        while (!halted && budget < 200) begin tick(1); budget++; end
        chk("halt_reached", {15'd0, halted}, 16'd1);
        tick(20);
        chk("halt_pc", {8'd0, tb_pc}, 16'h0000);
        chk("halt_d_op", {13'd0, d_op}, 16'd6);
        chk("final_r0", {8'd0, rf[0]}, 16'h0000);
        chk("final_r1", {8'd0, rf[1]}, 16'h0005);
        chk("final_r2", {8'd0, rf[2]}, 16'h0042);
        chk("final_r3", {8'd0, rf[3]}, 16'h005A);
        chk("final_r4", {8'd0, rf[4]}, 16'h00E2);
        chk("h_halted", {15'd0, halted_h}, 16'd1);
        chk("h_d_op", {13'd0, d_op_h}, 16'd6);
        chk("h_pc_in", {8'd0, pc_in_h}, 16'h0010);
        chk("h_rom_addr", {8'd0, rom_addr_h}, 16'h0010);
        chk("h_wb", {8'd0, wb_data_h}, 16'h0000);
        chk("h_sel", {7'd0, rx_op_h, ry_op_h, alu_op_h}, 16'h0000);
        chk("h_done", {15'd0, instr_done_h}, 16'd0);

        // Reset during DECODE of LDI r0,0x77 must abort without a write.
        run = 1'b0;
        rom[8'h00] = 16'h7077; rom[8'h01] = 16'hF000;
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        done_cnt = 0;
        run = 1'b1;
        tick(2);
        rst = 1'b1; run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("abort_r0", {8'd0, rf[0]}, 16'h0000);
        chk("abort_pc", {8'd0, tb_pc}, 16'h0000);
        chk("abort_done", 16'(done_cnt), 16'd0);

        // Restart after reset executes the instruction normally.
        run = 1'b1;
        budget = 0;
        while (!halted && budget < 30) begin tick(1); budget++; end
        chk("restart_halted", {15'd0, halted}, 16'd1);
        chk("restart_r0", {8'd0, rf[0]}, 16'h0077);
        chk("restart_pc", {8'd0, tb_pc}, 16'h0001);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
